pong_object_ctrl: RTL

//  Game-state engine for the lab5 pong display. Owns paddle and ball positions
//  and feeds paddle_y/ball_x/ball_y to the pixel generator on the same clock.

---
 rtl/pong_object_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pong_object_ctrl.sv
// Pong game-state engine: paddle/ball positions, bounces, hits and misses,
// updated once per video frame on a vertical-blanking tick.
module pong_object_ctrl #(
    parameter int unsigned PAD_V       = 4,
    parameter int unsigned BALL_V      = 2,
    parameter int unsigned MISS_FRAMES = 60,
    parameter int unsigned TICK_Y      = 481
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       serve,
    output logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] hits,
    output logic       miss
);

    localparam int unsigned PAD_H     = 72;
    localparam int unsigned BALL_S    = 8;
    localparam int unsigned PAD_MAX   = 479 - PAD_H;
    localparam int unsigned PAD_X_L   = 600;
    localparam int unsigned PAD_X_R   = 603;
    localparam int unsigned WALL_X    = 36;
    localparam int unsigned BOT_Y     = 479;
    localparam int unsigned PAD_Y0    = 204;
    localparam int unsigned BALL_X0   = 320;
    localparam int unsigned BALL_Y0   = 236;
    localparam int unsigned CNT_W     = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_MISS  = 2'd2;

    logic [1:0]       state, state_next;
    logic [9:0]       paddle_next, ball_x_next, ball_y_next;
    logic             dx, dx_next, dy, dy_next;
    logic [7:0]       hits_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             miss_next;
    logic             raw, raw_q, tick;

    logic [10:0] bx, by, bx_r, by_b, pad_t, pad_b;
    logic        hit, lose;

    // Single-clock frame tick, robust to pixel_x dwelling at 0
    assign raw  = (pixel_y == 10'(TICK_Y)) && (pixel_x == 10'd0);
    assign tick = raw & ~raw_q;

    // 11-bit operands so no comparison can wrap
    assign bx    = 11'(ball_x);
    assign by    = 11'(ball_y);
    assign bx_r  = 11'(ball_x) + 11'(BALL_S);
    assign by_b  = 11'(ball_y) + 11'(BALL_S);
    assign pad_t = 11'(paddle_y);
    assign pad_b = 11'(paddle_y) + 11'(PAD_H);

    assign hit  = dx && (bx_r >= 11'(PAD_X_L - BALL_V)) && (bx_r <= 11'(PAD_X_R))
                     && (by_b >= pad_t) && (by <= pad_b);
    assign lose = dx && (bx_r > 11'(PAD_X_R)) && !hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_SERVE;
            paddle_y <= 10'(PAD_Y0);
            ball_x   <= 10'(BALL_X0);
            ball_y   <= 10'(BALL_Y0);
            dx       <= 1'b1;
            dy       <= 1'b1;
            hits     <= 8'd0;
            cnt      <= '0;
            miss     <= 1'b0;
            raw_q    <= 1'b0;
        end else begin
            state    <= state_next;
            paddle_y <= paddle_next;
            ball_x   <= ball_x_next;
            ball_y   <= ball_y_next;
            dx       <= dx_next;
            dy       <= dy_next;
            hits     <= hits_next;
            cnt      <= cnt_next;
            miss     <= miss_next;
            raw_q    <= raw;
        end
    end

    always_comb begin
        state_next  = state;
        paddle_next = paddle_y;
        ball_x_next = ball_x;
        ball_y_next = ball_y;
        dx_next     = dx;
        dy_next     = dy;
        hits_next   = hits;
        cnt_next    = cnt;
        miss_next   = 1'b0;

        if (tick) begin
            if (btn_up && !btn_down)
                paddle_next = (pad_t >= 11'(PAD_V)) ? paddle_y - 10'(PAD_V) : 10'd0;
            else if (btn_down && !btn_up)
                paddle_next = (pad_t + 11'(PAD_V) <= 11'(PAD_MAX)) ? paddle_y + 10'(PAD_V)
                                                                   : 10'(PAD_MAX);

            case (state)
                ST_SERVE: begin
                    if (serve) begin
                        dx_next    = 1'b1;
                        dy_next    = 1'b1;
                        hits_next  = 8'd0;
                        state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (by <= 11'(BALL_V))
                        dy_next = 1'b1;
                    else if (by_b >= 11'(BOT_Y - BALL_V))
                        dy_next = 1'b0;
                    if (bx <= 11'(WALL_X + BALL_V))
                        dx_next = 1'b1;
                    if (hit) begin
                        dx_next = 1'b0;
                        if (hits != 8'hFF)
                            hits_next = hits + 8'd1;
                    end
                    if (lose) begin
                        state_next = ST_MISS;
                        miss_next  = 1'b1;
                    end else begin
                        ball_x_next = dx_next ? ball_x + 10'(BALL_V) : ball_x - 10'(BALL_V);
                        ball_y_next = dy_next ? ball_y + 10'(BALL_V) : ball_y - 10'(BALL_V);
                    end
                end
                ST_MISS: begin
                    if (cnt == CNT_W'(MISS_FRAMES - 1)) begin
                        cnt_next    = '0;
                        ball_x_next = 10'(BALL_X0);
                        ball_y_next = 10'(BALL_Y0);
                        state_next  = ST_SERVE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = ST_SERVE;
            endcase
        end
    end

endmodule
